// File: rtl/beam_threshold_servo.sv
// Per-beam trigger-rate servo: count triggers over a window, nudge each beam threshold
// toward target_i, then stream the thresholds out and commit. Optional macro: SERVO_DEADBAND_EN.
module beam_threshold_servo #(
    parameter int          NBEAMS         = 2,
    parameter int          PERIOD_CLOCKS  = 375000000,
    parameter int          HOLDOFF_CLOCKS = 16,
    parameter int          STEP           = 16,
    parameter logic [17:0] THRESH_INIT    = 18'h01000,
    parameter logic [17:0] THRESH_MIN     = 18'h00000,
    parameter logic [17:0] THRESH_MAX     = 18'h3FFFF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [31:0]       target_i,
`ifdef SERVO_DEADBAND_EN
    input  logic [31:0]       deadband_i,
`endif
    input  logic [NBEAMS-1:0] trig_i,
    output logic [17:0]       thresh_o,
    output logic [NBEAMS-1:0] thresh_ce_o,
    output logic              update_o,
    output logic              busy_o,
    output logic              done_o
);
    localparam int IDXW = (NBEAMS > 1) ? $clog2(NBEAMS) : 1;
    localparam int WINW = (PERIOD_CLOCKS > 1) ? $clog2(PERIOD_CLOCKS + 1) : 1;
    localparam int HOW  = (HOLDOFF_CLOCKS > 0) ? $clog2(HOLDOFF_CLOCKS + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_COUNT, S_ADJUST, S_LOAD, S_UPDATE, S_DONE
    } state_t;

    state_t                          r_state, w_next;
    logic [WINW-1:0]                 r_win;
    logic [IDXW-1:0]                 r_idx;
    logic                            r_phase;
    logic [NBEAMS-1:0][31:0]         r_cnt;
    logic [NBEAMS-1:0][HOW-1:0]      r_hold;
    logic [NBEAMS-1:0][17:0]         r_thresh;
    logic [31:0]                     w_tol;

`ifdef SERVO_DEADBAND_EN
    logic [31:0] r_tol;
    assign w_tol = r_tol;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                              r_tol <= '0;
        else if (r_state == S_IDLE && start_i)  r_tol <= deadband_i;
    end
`else
    assign w_tol = 32'd0;
`endif

    logic            w_last_win, w_last_beam;
    logic [31:0]     w_cnt_sel;
    logic [17:0]     w_thr_sel, w_adj;
    logic [32:0]     w_hi, w_lo;
    logic [18:0]     w_up;
    logic            w_dn_ok;

    assign w_last_win  = (r_win == WINW'(PERIOD_CLOCKS - 1));
    assign w_last_beam = (r_idx == IDXW'(NBEAMS - 1));
    assign w_cnt_sel   = r_cnt[r_idx];
    assign w_thr_sel   = r_thresh[r_idx];

    // Bounds are 33-bit so target+tol cannot wrap and target-tol clamps at zero.
    assign w_hi    = {1'b0, target_i} + {1'b0, w_tol};
    assign w_lo    = (target_i >= w_tol) ? ({1'b0, target_i} - {1'b0, w_tol}) : 33'd0;
    assign w_up    = {1'b0, w_thr_sel} + 19'(STEP);
    assign w_dn_ok = ({1'b0, w_thr_sel} >= ({1'b0, THRESH_MIN} + 19'(STEP)));

    always_comb begin
        w_adj = w_thr_sel;
        if ({1'b0, w_cnt_sel} > w_hi)
            w_adj = (w_up > {1'b0, THRESH_MAX}) ? THRESH_MAX : w_up[17:0];
        else if ({1'b0, w_cnt_sel} < w_lo)
            w_adj = w_dn_ok ? (w_thr_sel - 18'(STEP)) : THRESH_MIN;
    end

    always_comb begin
        w_next      = r_state;
        thresh_o    = '0;
        thresh_ce_o = '0;
        update_o    = 1'b0;
        done_o      = 1'b0;
        busy_o      = (r_state != S_IDLE);
        case (r_state)
            S_IDLE:   if (start_i) w_next = S_COUNT;
            S_COUNT:  if (w_last_win) w_next = S_ADJUST;
            S_ADJUST: if (w_last_beam) w_next = S_LOAD;
            S_LOAD: begin
                thresh_o = w_thr_sel;
                for (int b = 0; b < NBEAMS; b++)
                    thresh_ce_o[b] = r_phase && (r_idx == IDXW'(b));
                if (r_phase && w_last_beam) w_next = S_UPDATE;
            end
            S_UPDATE: begin
                update_o = 1'b1;
                w_next   = S_DONE;
            end
            S_DONE: begin
                done_o = 1'b1;
                w_next = S_IDLE;
            end
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_win    <= '0;
            r_idx    <= '0;
            r_phase  <= 1'b0;
            r_cnt    <= '0;
            r_hold   <= '0;
            r_thresh <= {NBEAMS{THRESH_INIT}};
        end else begin
            r_state <= w_next;
            // Holdoff runs in every state; only COUNT may re-arm it.
            for (int b = 0; b < NBEAMS; b++) begin
                if (r_hold[b] != '0) r_hold[b] <= r_hold[b] - 1'b1;
                if (r_state == S_COUNT && trig_i[b] && r_hold[b] == '0) begin
                    r_hold[b] <= HOW'(HOLDOFF_CLOCKS);
                    if (r_cnt[b] != 32'hFFFFFFFF) r_cnt[b] <= r_cnt[b] + 1'b1;
                end
            end
            case (r_state)
                S_IDLE: if (start_i) begin
                    r_win   <= '0;
                    r_cnt   <= '0;
                    r_idx   <= '0;
                    r_phase <= 1'b0;
                end
                S_COUNT: r_win <= r_win + 1'b1;
                S_ADJUST: begin
                    r_thresh[r_idx] <= w_adj;
                    r_idx           <= w_last_beam ? '0 : r_idx + 1'b1;
                end
                S_LOAD: begin
                    r_phase <= ~r_phase;
                    if (r_phase) r_idx <= r_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
